// File: rtl/axi_burst_write_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axi_burst_write_master: single-outstanding AXI4 INCR burst write source  |
// | Data is an incrementing pattern from a per-command seed. Optional        |
// | AXI_BWM_AW_W_PARALLEL_EN issues AW and W concurrently.                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module axi_burst_write_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int M_ID   = 0,
  parameter int LEN_W  = 4
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic [DATA_W-1:0]   cmd_data,
  output logic                rsp_valid,
  output logic [1:0]          rsp_resp,
  output logic [ID_W-1:0]     M_AWID,
  output logic [ADDR_W-1:0]   M_AWADDR,
  output logic [LEN_W-1:0]    M_AWLEN,
  output logic [2:0]          M_AWSIZE,
  output logic [1:0]          M_AWBURST,
  output logic                M_AWVALID,
  input  logic                M_AWREADY,
  output logic [DATA_W-1:0]   M_WDATA,
  output logic [DATA_W/8-1:0] M_WSTRB,
  output logic                M_WLAST,
  output logic                M_WVALID,
  input  logic                M_WREADY,
  input  logic [ID_W-1:0]     M_BID,
  input  logic [1:0]          M_BRESP,
  input  logic                M_BVALID,
  output logic                M_BREADY
);

  localparam int BYTES = DATA_W / 8;
  localparam int SIZE  = $clog2(BYTES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    beat_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                bready_q;
  logic                rsp_valid_q;
  logic [1:0]          rsp_resp_q;
  logic                accept, cross_4k, aw_hs, w_hs, w_last, b_hs;
  logic [31:0]         span_end;

  assign accept   = cmd_valid && (state == S_IDLE);
  assign span_end = 32'(cmd_addr[11:0]) + (32'(cmd_len) + 32'd1) * 32'(BYTES);
  assign cross_4k = span_end > 32'd4096;
  assign w_last   = (beat_q == len_q);
  assign aw_hs    = M_AWVALID && M_AWREADY;
  assign w_hs     = M_WVALID && M_WREADY;
  assign b_hs     = bready_q && M_BVALID;

`ifdef AXI_BWM_AW_W_PARALLEL_EN
  logic aw_done_q, w_done_q;
  assign M_AWVALID = (state == S_ADDR) && !aw_done_q;
  assign M_WVALID  = (state == S_ADDR) && !w_done_q;
`else
  assign M_AWVALID = (state == S_ADDR);
  assign M_WVALID  = (state == S_DATA);
`endif

  assign cmd_ready = (state == S_IDLE);
  assign M_AWID    = (state == S_IDLE) ? '0 : ID_W'(M_ID);
  assign M_AWADDR  = addr_q;
  assign M_AWLEN   = len_q;
  assign M_AWSIZE  = 3'(SIZE);
  assign M_AWBURST = 2'b01;
  assign M_WDATA   = wdata_q;
  assign M_WSTRB   = '1;
  assign M_WLAST   = M_WVALID && w_last;
  assign M_BREADY  = bready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_resp  = rsp_resp_q;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = cross_4k ? S_IDLE : S_ADDR;
`ifdef AXI_BWM_AW_W_PARALLEL_EN
      S_ADDR: if ((aw_done_q || aw_hs) && (w_done_q || (w_hs && w_last)))
                state_nxt = S_RESP;
`else
      S_ADDR: if (aw_hs) state_nxt = S_DATA;
`endif
      S_DATA: if (w_hs && w_last) state_nxt = S_RESP;
      S_RESP: if (b_hs) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state       <= S_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      wdata_q     <= '0;
      bready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_resp_q  <= 2'b00;
    end else begin
      state       <= state_nxt;
      rsp_valid_q <= 1'b0;
      // BREADY is registered, so it rises one cycle after RESP is entered
      bready_q    <= (state == S_RESP) && !b_hs;
      if (accept) begin
        addr_q  <= cmd_addr & ~ADDR_W'(BYTES - 1);
        len_q   <= cmd_len;
        wdata_q <= cmd_data;
        beat_q  <= '0;
        if (cross_4k) begin
          rsp_valid_q <= 1'b1;
          rsp_resp_q  <= 2'b10;
        end
      end
      if (w_hs) begin
        wdata_q <= wdata_q + DATA_W'(1);
        beat_q  <= beat_q + LEN_W'(1);
      end
      if (b_hs) begin
        rsp_valid_q <= 1'b1;
        rsp_resp_q  <= (M_BID == ID_W'(M_ID)) ? M_BRESP : 2'b10;
      end
    end
  end

`ifdef AXI_BWM_AW_W_PARALLEL_EN
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else if (accept) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      if (aw_hs)           aw_done_q <= 1'b1;
      if (w_hs && w_last)  w_done_q  <= 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_burst_write_master.sv
`default_nettype none
// Scoreboard bench for axi_burst_write_master: randomized commands against a
// burst-level reference model, with a reactive AXI slave.
module tb_axi_burst_write_master;
  localparam int ADDR_W = 32, DATA_W = 32, ID_W = 4, M_ID = 0, LEN_W = 4;
`ifdef AXI_BWM_AW_W_PARALLEL_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic ACLK = 1'b0, ARESET = 1'b1;
  logic cmd_valid, cmd_ready, rsp_valid;
  logic [31:0] cmd_addr, cmd_data;
  logic [3:0] cmd_len;
  logic [1:0] rsp_resp;
  logic [3:0] M_AWID, M_AWLEN, M_BID;
  logic [31:0] M_AWADDR, M_WDATA;
  logic [2:0] M_AWSIZE;
  logic [1:0] M_AWBURST, M_BRESP;
  logic [3:0] M_WSTRB;
  logic M_AWVALID, M_AWREADY, M_WLAST, M_WVALID, M_WREADY, M_BVALID, M_BREADY;

  always #5 ACLK = ~ACLK;

  axi_burst_write_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W),
                           .M_ID(M_ID), .LEN_W(LEN_W)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_resp(rsp_resp),
    .M_AWID(M_AWID), .M_AWADDR(M_AWADDR), .M_AWLEN(M_AWLEN), .M_AWSIZE(M_AWSIZE),
    .M_AWBURST(M_AWBURST), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
    .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WLAST(M_WLAST), .M_WVALID(M_WVALID),
    .M_WREADY(M_WREADY), .M_BID(M_BID), .M_BRESP(M_BRESP), .M_BVALID(M_BVALID),
    .M_BREADY(M_BREADY)
  );

  typedef struct packed { logic [31:0] addr; logic [3:0] len; } aw_t;
  typedef struct packed { logic [31:0] data; logic last; } w_t;
  aw_t        exp_aw[$];
  w_t         exp_w[$];
  logic [1:0] exp_rsp[$];
  int         exp_lat[$];

  int total = 0, bad = 0, cyc = 0, acc_cyc = 0, w_count = 0;
  int aw_stall = 0, wr_mode = 0;
  logic [3:0] b_id = 4'd0;
  logic [1:0] b_resp = 2'b00;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT hands something out
  initial begin : monitor
    logic prev_awv, prev_aw_stall, prev_w_stall, prev_wlast;
    logic [31:0] prev_awaddr, prev_wdata;
    logic [3:0] prev_awlen;
    aw_t ea; w_t ew; logic [1:0] er; int el;
    prev_awv = 0; prev_aw_stall = 0; prev_w_stall = 0; prev_wlast = 0;
    prev_awaddr = 0; prev_wdata = 0; prev_awlen = 0;
    forever begin
      @(negedge ACLK);
      cyc++;
      if (ARESET) begin
        prev_awv = 0; prev_aw_stall = 0; prev_w_stall = 0;
      end else begin
        if (cmd_valid && cmd_ready) acc_cyc = cyc;
        if (prev_aw_stall) begin
          check("aw_hold_valid", 64'(M_AWVALID), 64'(1));
          check("aw_hold_addr", 64'(M_AWADDR), 64'(prev_awaddr));
          check("aw_hold_len", 64'(M_AWLEN), 64'(prev_awlen));
        end
        if (prev_w_stall) begin
          check("w_hold_valid", 64'(M_WVALID), 64'(1));
          check("w_hold_data", 64'(M_WDATA), 64'(prev_wdata));
          check("w_hold_last", 64'(M_WLAST), 64'(prev_wlast));
        end
        if (M_AWVALID && !prev_awv) check("wvalid_at_aw_rise", 64'(M_WVALID), 64'(PAR));
        if (exp_aw.size() == 0) check("aw_valid_no_cmd", 64'(M_AWVALID), 64'(0));
        if (exp_w.size() == 0) check("w_valid_no_cmd", 64'(M_WVALID), 64'(0));
        if (M_AWVALID && M_AWREADY && exp_aw.size() != 0) begin
          ea = exp_aw.pop_front();
          check("aw_addr", 64'(M_AWADDR), 64'(ea.addr));
          check("aw_len", 64'(M_AWLEN), 64'(ea.len));
          check("aw_size_burst_id", 64'({M_AWSIZE, M_AWBURST, M_AWID}), 64'({3'd2, 2'b01, 4'(M_ID)}));
        end
        if (M_WVALID && M_WREADY && exp_w.size() != 0) begin
          ew = exp_w.pop_front();
          w_count++;
          check("w_data", 64'(M_WDATA), 64'(ew.data));
          check("w_last", 64'(M_WLAST), 64'(ew.last));
          check("w_strb", 64'(M_WSTRB), 64'(4'hF));
        end
        if (exp_rsp.size() == 0) check("rsp_valid_no_cmd", 64'(rsp_valid), 64'(0));
        else if (rsp_valid) begin
          er = exp_rsp.pop_front();
          el = exp_lat.pop_front();
          check("rsp_resp", 64'(rsp_resp), 64'(er));
          check("rsp_cmd_ready", 64'(cmd_ready), 64'(1));
          if (el >= 0) check("latency", 64'(cyc - acc_cyc), 64'(el));
        end
        prev_awv = M_AWVALID;
        prev_aw_stall = M_AWVALID && !M_AWREADY;
        prev_w_stall = M_WVALID && !M_WREADY;
        prev_awaddr = M_AWADDR; prev_awlen = M_AWLEN;
        prev_wdata = M_WDATA; prev_wlast = M_WLAST;
      end
    end
  end

  // Reactive slave: AWREADY after aw_stall waiting cycles, WREADY per wr_mode,
  // B issued once both the AW and the last W handshakes have been seen
  initial begin : slave
    int aw_wait;
    logic awf, wf, bf, aw_seen, w_seen;
    aw_wait = 0; aw_seen = 0; w_seen = 0;
    M_AWREADY = 0; M_WREADY = 0; M_BVALID = 0; M_BID = 0; M_BRESP = 0;
    forever begin
      @(negedge ACLK);
      awf = M_AWVALID && M_AWREADY;
      wf  = M_WVALID && M_WREADY && M_WLAST;
      bf  = M_BVALID && M_BREADY;
      if (M_AWVALID && !M_AWREADY) aw_wait++;
      @(posedge ACLK); #1;
      if (awf) begin aw_seen = 1; aw_wait = 0; end
      if (wf) w_seen = 1;
      if (bf) M_BVALID = 0;
      if (ARESET) begin aw_seen = 0; w_seen = 0; aw_wait = 0; M_BVALID = 0; end
      M_AWREADY = (aw_wait >= aw_stall);
      case (wr_mode)
        0: M_WREADY = 1'b1;
        1: M_WREADY = !M_WREADY;
        default: M_WREADY = 1'($urandom_range(0, 1));
      endcase
      if (aw_seen && w_seen && !M_BVALID) begin
        M_BVALID = 1; M_BID = b_id; M_BRESP = b_resp;
        aw_seen = 0; w_seen = 0;
      end
    end
  end

  task automatic set_slave(input int st, input int wm, input logic [3:0] id, input logic [1:0] rs);
    aw_stall = st; wr_mode = wm; b_id = id; b_resp = rs;
  endtask

  // Reference model: one burst's expected AW, W beats, response and latency
  task automatic send(input logic [31:0] a, input logic [3:0] l, input logic [31:0] d);
    int beats;
    bit err, acc;
    beats = int'(l) + 1;
    err = (int'(a[11:0]) + beats * 4) > 4096;
    if (!err) begin
      exp_aw.push_back('{addr: a & ~32'h3, len: l});
      for (int k = 0; k < beats; k++)
        exp_w.push_back('{data: d + 32'(k), last: (k == beats - 1)});
    end
    exp_rsp.push_back(err ? 2'b10 : ((b_id == 4'(M_ID)) ? b_resp : 2'b10));
    exp_lat.push_back(err ? 1 : ((aw_stall == 0 && wr_mode == 0) ? beats + 4 - PAR : -1));
    @(posedge ACLK); #1;
    cmd_valid = 1; cmd_addr = a; cmd_len = l; cmd_data = d;
    acc = 0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge ACLK);
      acc = cmd_ready;
    end
    @(posedge ACLK); #1;
    cmd_valid = 0;
    if (!acc) check("cmd_accept_timeout", 64'(cmd_ready), 64'(1));
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400 && exp_rsp.size() != 0; i++) @(posedge ACLK);
    if (exp_rsp.size() != 0) begin
      check("rsp_timeout", 64'(exp_rsp.size()), 64'(0));
      exp_rsp.delete(); exp_lat.delete();
    end
    check("aw_left_over", 64'(exp_aw.size()), 64'(0));
    check("w_left_over", 64'(exp_w.size()), 64'(0));
    exp_aw.delete(); exp_w.delete();
  endtask

  initial begin : stim
    int w0;
    logic [31:0] ra;
    cmd_valid = 0; cmd_addr = 0; cmd_len = 0; cmd_data = 0;
    ARESET = 1;
    repeat (3) @(posedge ACLK);
    #1;
    check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    check("rst_valids", 64'({M_AWVALID, M_WVALID, M_BREADY, rsp_valid}), 64'(0));
    check("rst_addr_data_id", 64'({M_AWADDR, M_WDATA, M_AWID}), 64'(0));
    ARESET = 0;

    set_slave(0, 0, 4'(M_ID), 2'b00);
    send(32'h100, 4'd0, 32'hA5); wait_done();
    send(32'h0, 4'd15, 32'hFFFF_FFFE); wait_done();
    set_slave(5, 1, 4'(M_ID), 2'b00);
    send(32'h2000, 4'd7, $urandom); wait_done();
    set_slave(0, 0, 4'(M_ID), 2'b00);
    send(32'hFFC, 4'd1, 32'h1234); wait_done();
    set_slave(0, 0, 4'(M_ID + 1), 2'b00);
    send(32'h40, 4'd2, 32'h10); wait_done();
    set_slave(0, 0, 4'(M_ID), 2'b11);
    send(32'h80, 4'd3, 32'h20); wait_done();

    // Reset in the middle of an 8-beat burst
    set_slave(0, 1, 4'(M_ID), 2'b00);
    w0 = w_count;
    send(32'h3000, 4'd7, 32'h55);
    for (int i = 0; i < 100 && w_count < w0 + 3; i++) @(posedge ACLK);
    check("reset_reached_beat3", 64'(w_count - w0 >= 3), 64'(1));
    #3 ARESET = 1;
    #1;
    check("arst_valids", 64'({M_AWVALID, M_WVALID, M_BREADY, rsp_valid}), 64'(0));
    check("arst_cmd_ready", 64'(cmd_ready), 64'(1));
    check("arst_data", 64'(M_WDATA), 64'(0));
    exp_aw.delete(); exp_w.delete(); exp_rsp.delete(); exp_lat.delete();
    repeat (2) @(posedge ACLK);
    #3 ARESET = 0;
    @(negedge ACLK);
    check("post_rst_cmd_ready", 64'(cmd_ready), 64'(1));
    set_slave(0, 0, 4'(M_ID), 2'b00);
    send(32'h4000, 4'd4, 32'h77); wait_done();

    for (int n = 0; n < 25; n++) begin
      ra = $urandom;
      if ($urandom_range(0, 2) == 0) ra[11:0] = {4'hF, 8'($urandom)};
      set_slave($urandom_range(0, 3), $urandom_range(0, 2), 4'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) set_slave(0, 0, b_id, b_resp);
      send(ra, 4'($urandom), $urandom);
      wait_done();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
